// File: rtl/donkey_pkg.sv
`default_nettype none
// ============================================================================
// Module      : donkey_pkg
// Description : Types and widths shared by the Donkey life-tracking logic.
//               - health_state_t : life FSM state encoding (2 bits)
//               - LIVES_W        : width of the lives counter
//               - FRAME_CNT_W    : width of the frame counters
// Revision    : 1.0 - initial release
// ============================================================================
package donkey_pkg;

    localparam int LIVES_W     = 3;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        GRACE = 2'd2,
        DEAD  = 2'd3
    } health_state_t;

endpackage
`default_nettype wire

// File: rtl/grace_timer.sv
`default_nettype none
// ============================================================================
// Module      : grace_timer
// Description : Frame counter used for the invulnerability window and for the
//               sprite blink half-period. Counts enabled cycles; on the
//               enabled cycle where the count equals `limit` it pulses `done`
//               and wraps to zero.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               clear       - forces the count to zero (wins over en)
//               en          - count this cycle (frame tick while in GRACE)
//               limit       - terminal count (period - 1)
//               done        - high on the enabled cycle that hits limit
// Revision    : 1.0 - initial release
// ============================================================================
module grace_timer
    import donkey_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [FRAME_CNT_W-1:0] limit,
    output logic                   done
);

    logic [FRAME_CNT_W-1:0] r_count;

    // Combinational so the owner can act on the same edge the limit is reached.
    assign done = en && (r_count == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (done) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + FRAME_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/donkey_health.sv
`default_nettype none
// ============================================================================
// Module      : donkey_health
// Description : Tracks Donkey's remaining lives downstream of the shield
//               stage. Every hit (absorbed or not) starts a frame-counted
//               invulnerability window during which the sprite blinks.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               game_en       - game running; low returns to IDLE
//               frame_tick    - one-cycle pulse per video frame
//               hit[9:0]      - per-barrel collision levels
//               is_shielded   - shield flag (same-cycle value governs)
//               lives[2:0]    - remaining lives
//               invulnerable  - high while in GRACE
//               blink         - sprite blink phase, 0 outside GRACE
//               life_lost     - one-cycle pulse on each deducted life
//               game_over     - high in DEAD
// Revision    : 1.0 - initial release
// ============================================================================
module donkey_health
    import donkey_pkg::*;
#(
    parameter int MAX_LIVES    = 3,
    parameter int GRACE_FRAMES = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               frame_tick,
    input  logic [9:0]         hit,
    input  logic               is_shielded,
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               blink,
    output logic               life_lost,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0]     c_MAX_LIVES   = LIVES_W'(MAX_LIVES);
    localparam logic [FRAME_CNT_W-1:0] c_GRACE_LIMIT = FRAME_CNT_W'(GRACE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] c_BLINK_LIMIT = FRAME_CNT_W'(BLINK_FRAMES - 1);

    health_state_t        r_state;
    health_state_t        w_next_state;
    logic [LIVES_W-1:0]   r_lives;
    logic [LIVES_W-1:0]   w_lives_nxt;
    logic                 r_blink;
    logic                 w_blink_nxt;
    logic                 r_life_lost;
    logic                 w_life_lost_nxt;
    logic                 r_invulnerable;
    logic                 r_game_over;

    logic                 w_tmr_en;
    logic                 w_tmr_clear;
    logic                 w_grace_done;
    logic                 w_blink_done;

    // Ticks are only counted once GRACE is the current state, so a tick that
    // coincides with the entering edge is not part of the window.
    assign w_tmr_en    = frame_tick && (r_state == GRACE);
    // Hold both counters at zero outside GRACE and wipe them on any exit
    // (expiry or game_en drop), so every window starts fresh.
    assign w_tmr_clear = (r_state != GRACE) || (w_next_state != GRACE);

    grace_timer u_grace_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tmr_clear),
        .en    (w_tmr_en),
        .limit (c_GRACE_LIMIT),
        .done  (w_grace_done)
    );

    grace_timer u_blink_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_tmr_clear),
        .en    (w_tmr_en),
        .limit (c_BLINK_LIMIT),
        .done  (w_blink_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_lives        <= c_MAX_LIVES;
            r_blink        <= 1'b0;
            r_life_lost    <= 1'b0;
            r_invulnerable <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_lives        <= w_lives_nxt;
            r_blink        <= w_blink_nxt;
            r_life_lost    <= w_life_lost_nxt;
            r_invulnerable <= (w_next_state == GRACE);
            r_game_over    <= (w_next_state == DEAD);
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_lives_nxt     = r_lives;
        w_blink_nxt     = r_blink;
        w_life_lost_nxt = 1'b0;

        if (!game_en) begin
            // Leaving the game outranks any collision in the same cycle.
            w_next_state = IDLE;
            w_lives_nxt  = c_MAX_LIVES;
            w_blink_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state = ALIVE;
                end
                ALIVE: begin
                    if (hit != '0) begin
                        if (is_shielded) begin
                            w_next_state = GRACE;
                        end else begin
                            w_life_lost_nxt = 1'b1;
                            if (r_lives <= LIVES_W'(1)) begin
                                w_lives_nxt  = '0;
                                w_next_state = DEAD;
                            end else begin
                                w_lives_nxt  = r_lives - LIVES_W'(1);
                                w_next_state = GRACE;
                            end
                        end
                    end
                end
                GRACE: begin
                    if (w_grace_done) begin
                        w_next_state = ALIVE;
                        w_blink_nxt  = 1'b0;
                    end else if (w_blink_done) begin
                        w_blink_nxt = ~r_blink;
                    end
                end
                DEAD: begin
                    w_lives_nxt = '0;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign lives        = r_lives;
    assign invulnerable = r_invulnerable;
    assign blink        = r_blink;
    assign life_lost    = r_life_lost;
    assign game_over    = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_donkey_health.sv
`default_nettype none
// ============================================================================
// Module      : tb_donkey_health
// Description : Self-checking bench for donkey_health. Stimulus is driven on
//               the falling edge; the expected outputs for the following
//               rising edge are queued and compared 1 ns after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_donkey_health;

    localparam int GF = 120;
    localparam int BF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] hit = '0;
    logic       is_shielded = 1'b0;
    logic [2:0] lives;
    logic       invulnerable;
    logic       blink;
    logic       life_lost;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    donkey_health #(
        .MAX_LIVES    (3),
        .GRACE_FRAMES (GF),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_en      (game_en),
        .frame_tick   (frame_tick),
        .hit          (hit),
        .is_shielded  (is_shielded),
        .lives        (lives),
        .invulnerable (invulnerable),
        .blink        (blink),
        .life_lost    (life_lost),
        .game_over    (game_over)
    );

    typedef struct {
        bit         r;
        bit         ge;
        bit         tk;
        logic [9:0] h;
        bit         sh;
        logic [2:0] lv;
        bit         inv;
        bit         bl;
        bit         ll;
        bit         go;
        string      name;
    } vec_t;

    typedef struct {
        logic [6:0] v;   // {lives, invulnerable, blink, life_lost, game_over}
        string      name;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer: one queued expectation per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = sb.pop_front();
            act = {lives, invulnerable, blink, life_lost, game_over};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got lives=%0d inv=%b blink=%b ll=%b go=%b, expected lives=%0d inv=%b blink=%b ll=%b go=%b",
                         e.name, act[6:4], act[3], act[2], act[1], act[0],
                         e.v[6:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic step(input bit r, input bit ge, input bit tk, input logic [9:0] h,
                        input bit sh, input logic [2:0] lv, input bit inv, input bit bl,
                        input bit ll, input bit go, input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        game_en     = ge;
        frame_tick  = tk;
        hit         = h;
        is_shielded = sh;
        e.v    = {lv, inv, bl, ll, go};
        e.name = nm;
        sb.push_back(e);
    endtask

    // Runs n frame ticks inside a GRACE window that started with the count at
    // zero. Expected blink after k ticks is floor(k/BF) mod 2 while the window
    // lasts; both flags drop after tick GF.
    task automatic grace_run(input logic [9:0] h, input logic [2:0] lv,
                             input int n, input bit gap, input string nm);
        for (int k = 1; k <= n; k++) begin
            bit inv_e;
            bit bl_e;
            inv_e = (k < GF);
            bl_e  = (k < GF) ? (((k / BF) % 2) == 1) : 1'b0;
            step(0, 1, 1, h, 0, lv, inv_e, bl_e, 0, 0, nm);
            if (gap && k < n) begin
                step(0, 1, 0, h, 0, lv, inv_e, bl_e, 0, 0, nm);
            end
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 0, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "reset"};
        tbl[1] = '{0, 0, 1, 10'h004, 0, 3'd3, 0, 0, 0, 0, "idle_hold"};
        tbl[2] = '{0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "to_alive"};
        tbl[3] = '{0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "alive_quiet"};
        tbl[4] = '{0, 1, 0, 10'h004, 0, 3'd2, 1, 0, 1, 0, "hit_unshielded"};
        tbl[5] = '{0, 1, 0, 10'h000, 0, 3'd2, 1, 0, 0, 0, "life_lost_pulse_end"};
        tbl[6] = '{0, 1, 0, 10'h3ff, 0, 3'd2, 1, 0, 0, 0, "hit_ignored_in_grace"};
        tbl[7] = '{0, 1, 0, 10'h200, 1, 3'd2, 1, 0, 0, 0, "shield_ignored_in_grace"};
        tbl[8] = '{0, 1, 0, 10'h000, 0, 3'd2, 1, 0, 0, 0, "grace_idle"};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].ge, tbl[i].tk, tbl[i].h, tbl[i].sh,
                 tbl[i].lv, tbl[i].inv, tbl[i].bl, tbl[i].ll, tbl[i].go, tbl[i].name);
        end

        // Full window with idle cycles between ticks.
        grace_run(10'h000, 3'd2, GF, 1, "grace_expiry_1");
        step(0, 1, 0, 10'h000, 0, 3'd2, 0, 0, 0, 0, "alive_after_grace");

        // Shielded hit with a coincident tick: no life lost, tick not counted.
        step(0, 1, 1, 10'h001, 1, 3'd2, 1, 0, 0, 0, "hit_shielded");
        grace_run(10'h000, 3'd2, GF, 0, "grace_expiry_shield");

        // Hit held through the whole window.
        step(0, 1, 0, 10'h3ff, 0, 3'd1, 1, 0, 1, 0, "held_hit_first");
        grace_run(10'h3ff, 3'd1, GF, 0, "held_hit_grace");
        step(0, 1, 0, 10'h3ff, 0, 3'd0, 0, 0, 1, 1, "held_hit_fatal");
        step(0, 1, 1, 10'h3ff, 0, 3'd0, 0, 0, 0, 1, "dead_hit_ignored");
        step(0, 1, 0, 10'h010, 0, 3'd0, 0, 0, 0, 1, "dead_stays");

        // Leave the game, restart.
        step(0, 0, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "game_off_reload");
        step(0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "restart_alive");

        // Reset in the middle of a window (count at 50).
        step(0, 1, 0, 10'h008, 0, 3'd2, 1, 0, 1, 0, "hit_before_rst");
        grace_run(10'h000, 3'd2, 50, 0, "grace_to_50");
        step(1, 1, 1, 10'h008, 0, 3'd3, 0, 0, 0, 0, "rst_mid_grace");
        step(0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "post_rst_alive");
        step(0, 1, 0, 10'h080, 0, 3'd2, 1, 0, 1, 0, "post_rst_hit");
        grace_run(10'h000, 3'd2, GF, 0, "post_rst_full_grace");

        // game_en drop and hit in the same cycle.
        step(0, 0, 0, 10'h004, 0, 3'd3, 0, 0, 0, 0, "game_off_with_hit");
        step(0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "restart_alive_2");

        // game_en drop inside GRACE, after blink went high.
        step(0, 1, 0, 10'h002, 0, 3'd2, 1, 0, 1, 0, "hit_before_abort");
        grace_run(10'h000, 3'd2, 9, 0, "grace_to_9");
        step(0, 0, 1, 10'h000, 0, 3'd3, 0, 0, 0, 0, "abort_grace");
        step(0, 1, 0, 10'h000, 0, 3'd3, 0, 0, 0, 0, "restart_alive_3");
        step(0, 1, 0, 10'h001, 1, 3'd3, 1, 0, 0, 0, "shield_at_full");
        grace_run(10'h000, 3'd3, GF, 0, "grace_after_abort");

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 5 && sb.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
